// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port RAM between fetch, data and host requesters,
// with a host-exclusive lock and an issue/latency/done sequencer.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int RAM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   input  logic                  host_lock,
   output logic [2:0]            ack,
   output logic [DATA_W-1:0]     rdata,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   output logic                  ram_wren,
   input  logic [DATA_W-1:0]     ram_q,
   output logic                  busy,
   output logic [1:0]            cur_id
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, nxt;
   logic [1:0] id, rr_last, p1, p2, win, cnt;
   logic [2:0] elig;
   logic lwe, any;
   assign elig = host_lock ? {req[2], 2'b00} : req;
   assign any = |elig;
   // priority rotates so the requester after the last one served is checked first
   assign p1 = rr_last == 2'd2 ? 2'd0 : rr_last + 2'd1;
   assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
   assign win = elig[p1] ? p1 : elig[p2] ? p2 : rr_last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  nxt = any ? ISSUE : IDLE;
         ISSUE: nxt = lwe ? DONE : WAIT;
         WAIT:  nxt = cnt == 2'd0 ? DONE : WAIT;
         DONE:  nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         id        <= 2'd0;
         lwe       <= 1'b0;
         cnt       <= 2'd0;
         rr_last   <= 2'd2;
         rdata     <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         if (state == IDLE && any) begin
            id        <= win;
            lwe       <= we[win];
            ram_addr  <= addr[win*ADDR_W +: ADDR_W];
            ram_wdata <= wdata[win*DATA_W +: DATA_W];
         end
         if (state == ISSUE) cnt <= 2'(RAM_LAT - 1);
         if (state == WAIT) begin
            if (cnt == 2'd0) rdata <= ram_q;
            else cnt <= cnt - 2'd1;
         end
         if (state == DONE) rr_last <= id;
      end
   always_comb begin
      busy     = state != IDLE;
      cur_id   = busy ? id : 2'b11;
      ram_wren = state == ISSUE && lwe;
      ack      = state == DONE ? 3'b001 << id : 3'b000;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter, one lane at RAM_LAT=1 and one at RAM_LAT=3,
// expectations come from a transaction-level model of the arbitration and timing rules.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n, host_lock;
   int rate, ro, cyc = 0, checks = 0, failures = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input int lane, input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL lane%0d %s cyc=%0d got=%0h exp=%0h", lane, n, cyc, got, exp);
      end
   endtask
   function automatic logic [15:0] init_word(input int a);
      return 16'((a * 32'h1357) ^ 32'hA5C3);
   endfunction
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT = g == 0 ? 1 : 3;
      logic [2:0] req, we, ack;
      logic [47:0] addr, wdata;
      logic [15:0] rdata, ram_addr, ram_wdata, ram_q;
      logic ram_wren, busy;
      logic [1:0] cur_id;
      logic [15:0] mem [32];
      logic [15:0] pipe [3];
      mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(LAT)) dut (
         .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
         .host_lock(host_lock), .ack(ack), .rdata(rdata), .ram_addr(ram_addr),
         .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .cur_id(cur_id));
      // RAM: data for an address appears LAT clocks after it is presented
      initial begin
         for (int k = 0; k < 32; k++) mem[k] = init_word(k);
         forever begin
            @(posedge clk);
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= mem[ram_addr[4:0]];
            if (ram_wren) mem[ram_addr[4:0]] <= ram_wdata;
         end
      end
      assign ram_q = pipe[LAT-1];
      for (genvar i = 0; i < 3; i++) begin : rq
         logic r, w;
         logic [15:0] a, d;
         initial begin
            r = 1'b0; w = 1'b0; a = '0; d = '0;
            forever begin
               @(negedge clk);
               if (r && ack[i]) r = 1'b0;
               else if (!r && int'($urandom_range(0, 99)) < rate) begin
                  r = 1'b1;
                  w = ro != 0 ? 1'b0 : 1'($urandom_range(0, 1));
                  a = 16'($urandom) & 16'h801F;
                  d = 16'($urandom);
               end
            end
         end
      end
      assign req   = {rq[2].r, rq[1].r, rq[0].r};
      assign we    = {rq[2].w, rq[1].w, rq[0].w};
      assign addr  = {rq[2].a, rq[1].a, rq[0].a};
      assign wdata = {rq[2].d, rq[1].d, rq[0].d};
      int tail = 0, head = 0, nfree = 0, rr = 2, win;
      logic [2:0] el;
      logic [15:0] ref_mem [32];
      int e_id [2048], e_we [2048], e_g [2048], e_ack [2048];
      logic [15:0] e_a [2048], e_d [2048], e_rd [2048];
      // model: one transaction at a time, winner is first eligible after the last served
      initial begin
         for (int k = 0; k < 32; k++) ref_mem[k] = init_word(k);
         forever begin
            @(posedge clk);
            if (!rst_n) begin
               rr = 2;
               nfree = 0;
            end else if (cyc >= nfree) begin
               el = host_lock ? (req & 3'b100) : req;
               win = -1;
               for (int k = 1; k <= 3 && win < 0; k++) if (el[(rr + k) % 3]) win = (rr + k) % 3;
               if (win >= 0) begin
                  e_id[tail]  = win;
                  e_we[tail]  = int'(we[win]);
                  e_a[tail]   = addr[win*16 +: 16];
                  e_d[tail]   = wdata[win*16 +: 16];
                  e_g[tail]   = cyc;
                  e_ack[tail] = cyc + (we[win] ? 2 : LAT + 2);
                  e_rd[tail]  = ref_mem[e_a[tail][4:0]];
                  if (we[win]) ref_mem[e_a[tail][4:0]] = e_d[tail];
                  nfree = e_ack[tail] + 1;
                  rr = win;
                  tail++;
               end
            end
         end
      end
      logic [15:0] lrd, la, lwd;
      logic act, iss;
      logic [2:0] xack;
      initial forever begin
         @(negedge clk);
         if (!rst_n) begin
            head = tail;
            lrd = '0; la = '0; lwd = '0;
         end else begin
            act  = head < tail && cyc > e_g[head];
            xack = act && cyc == e_ack[head] ? 3'b001 << e_id[head] : 3'b000;
            iss  = act && cyc == e_g[head] + 1;
            if (iss) begin
               la = e_a[head];
               lwd = e_d[head];
            end
            if (xack != 3'b000 && e_we[head] == 0) lrd = e_rd[head];
            chk(g, "ack", int'(ack), int'(xack));
            chk(g, "busy", int'(busy), int'(act));
            chk(g, "cur_id", int'(cur_id), act ? e_id[head] : 3);
            chk(g, "ram_wren", int'(ram_wren), int'(iss && e_we[head] != 0));
            chk(g, "ram_addr", int'(ram_addr), int'(la));
            chk(g, "ram_wdata", int'(ram_wdata), int'(lwd));
            chk(g, "rdata", int'(rdata), int'(lrd));
            if (xack != 3'b000) head++;
         end
      end
      always @(negedge rst_n) begin
         #1;
         chk(g, "rst_ack", int'(ack), 0);
         chk(g, "rst_rdata", int'(rdata), 0);
         chk(g, "rst_ram_addr", int'(ram_addr), 0);
         chk(g, "rst_ram_wdata", int'(ram_wdata), 0);
         chk(g, "rst_ram_wren", int'(ram_wren), 0);
         chk(g, "rst_busy", int'(busy), 0);
         chk(g, "rst_cur_id", int'(cur_id), 3);
      end
   end
   initial begin
      rst_n = 1'b1; host_lock = 1'b0; rate = 100; ro = 1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // all requesters read from reset; third edge lands in the first WAIT of both lanes
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      host_lock = 1'b1;
      repeat (40) @(negedge clk);
      host_lock = 1'b0;
      repeat (20) @(negedge clk);
      ro = 0; rate = 40;
      for (int k = 0; k < 30; k++) begin
         host_lock = $urandom_range(0, 3) == 0;
         repeat (50) @(negedge clk);
      end
      rate = 0; host_lock = 1'b0;
      repeat (30) @(negedge clk);
      chk(0, "drain", lane[0].tail - lane[0].head, 0);
      chk(1, "drain", lane[1].tail - lane[1].head, 0);
      chk(0, "activity", int'(lane[0].tail > 100), 1);
      chk(1, "activity", int'(lane[1].tail > 100), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
